// File: rtl/peq_pkg.sv
// -----------------------------------------------------------------------------
// peq_pkg
// Shared constants for the parametric-EQ datapath blocks (curve reset/edit,
// gain application, display). Holds the default widths and the unity gain.
// No ports.
// -----------------------------------------------------------------------------
package peq_pkg;

   localparam int unsigned LOGFFTSIZE_DEF  = 13;
   localparam int unsigned AUDIOWIDTH_DEF  = 16;
   localparam int unsigned SATCNTWIDTH_DEF = 16;

   // Gain is unsigned Q1.(AUDIOWIDTH-1): unity is the MSB alone.
   localparam logic [AUDIOWIDTH_DEF-1:0] GAIN_UNITY = {1'b1, {(AUDIOWIDTH_DEF-1){1'b0}}};

   // Input bin to output bin, in clock cycles.
   localparam int unsigned GCAPPLY_LATENCY = 3;

endpackage

// File: rtl/gcapply_if.sv
// -----------------------------------------------------------------------------
// gcapply_if
// Bundles the bin stream in/out, the gain-curve RAM read port, curve_ready and
// the per-frame saturation count of gcapply.
//   master : the surrounding system (FFT, RAM, curve writer, IFFT)
//   slave  : gcapply itself
// -----------------------------------------------------------------------------
interface gcapply_if #(
   parameter int unsigned LOGFFTSIZE  = 13,
   parameter int unsigned AUDIOWIDTH  = 16,
   parameter int unsigned SATCNTWIDTH = 16
);
   logic                   in_valid;
   logic [LOGFFTSIZE-1:0]  in_index;
   logic [AUDIOWIDTH-1:0]  in_re;
   logic [AUDIOWIDTH-1:0]  in_im;
   logic                   in_last;
   logic                   curve_ready;
   logic [LOGFFTSIZE-1:0]  gcurve_addr;
   logic [AUDIOWIDTH-1:0]  gcurve_dout;
   logic                   out_valid;
   logic [LOGFFTSIZE-1:0]  out_index;
   logic [AUDIOWIDTH-1:0]  out_re;
   logic [AUDIOWIDTH-1:0]  out_im;
   logic                   out_last;
   logic [SATCNTWIDTH-1:0] sat_frame;

   modport master (
      output in_valid, in_index, in_re, in_im, in_last, curve_ready, gcurve_dout,
      input  gcurve_addr, out_valid, out_index, out_re, out_im, out_last, sat_frame
   );

   modport slave (
      input  in_valid, in_index, in_re, in_im, in_last, curve_ready, gcurve_dout,
      output gcurve_addr, out_valid, out_index, out_re, out_im, out_last, sat_frame
   );
endinterface

// File: rtl/gcapply_gcmul_sat.sv
// -----------------------------------------------------------------------------
// gcmul_sat
// Two-stage signed sample x unsigned gain: product register, then floor shift
// by AUDIOWIDTH-1 and clamp into the result register.
//   clk_i, rst_ni : clock, async active-low reset
//   prod_en_i     : load product register from sample_i * gain_i
//   out_en_i      : load result register from the shifted/clamped product
//   sample_i      : signed sample
//   gain_i        : unsigned gain, unity = 1<<(AUDIOWIDTH-1)
//   result_o      : registered clamped result (holds when out_en_i is low)
//   sat_o         : clamp flag for the value result_o loads on this edge
// -----------------------------------------------------------------------------
module gcmul_sat
   import peq_pkg::*;
#(
   parameter int unsigned AUDIOWIDTH = AUDIOWIDTH_DEF
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         prod_en_i,
   input  logic                         out_en_i,
   input  logic signed [AUDIOWIDTH-1:0] sample_i,
   input  logic        [AUDIOWIDTH-1:0] gain_i,
   output logic signed [AUDIOWIDTH-1:0] result_o,
   output logic                         sat_o
);
   localparam int unsigned PW = 2 * AUDIOWIDTH + 1;

   localparam logic signed [PW-1:0] PMAX = {{(AUDIOWIDTH+2){1'b0}}, {(AUDIOWIDTH-1){1'b1}}};
   localparam logic signed [PW-1:0] PMIN = {{(AUDIOWIDTH+2){1'b1}}, {(AUDIOWIDTH-1){1'b0}}};
   localparam logic signed [AUDIOWIDTH-1:0] OMAX = {1'b0, {(AUDIOWIDTH-1){1'b1}}};
   localparam logic signed [AUDIOWIDTH-1:0] OMIN = {1'b1, {(AUDIOWIDTH-1){1'b0}}};

   logic signed [PW-1:0]         a_ext, g_ext, prod_d, prod_q, shifted;
   logic signed [AUDIOWIDTH-1:0] result_d, result_q;
   logic                         hi, lo;

   always_comb begin
      // Sign-extend the sample, zero-extend the gain, multiply at full width.
      a_ext   = {{(AUDIOWIDTH+1){sample_i[AUDIOWIDTH-1]}}, sample_i};
      g_ext   = {{(AUDIOWIDTH+1){1'b0}}, gain_i};
      prod_d  = a_ext * g_ext;
      shifted = prod_q >>> (AUDIOWIDTH - 1);
      hi      = shifted > PMAX;
      lo      = shifted < PMIN;
      sat_o   = hi | lo;
      result_d = hi ? OMAX : (lo ? OMIN : shifted[AUDIOWIDTH-1:0]);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prod_q   <= '0;
         result_q <= '0;
      end else begin
         if (prod_en_i) prod_q   <= prod_d;
         if (out_en_i)  result_q <= result_d;
      end
   end

   assign result_o = result_q;

endmodule

// File: rtl/gcapply.sv
// -----------------------------------------------------------------------------
// gcapply
// Scales each forward-FFT bin (re and im) by its gain from the gcurve RAM and
// saturates, latency 3. Frames touched by a curve rewrite pass at unity.
//   clk, rst : clock, async active-low reset
//   bus      : gcapply_if.slave -- bin stream in/out, RAM read port
//              (gcurve_addr/gcurve_dout, 1-cycle read), curve_ready, sat_frame
// -----------------------------------------------------------------------------
module gcapply
   import peq_pkg::*;
#(
   parameter int unsigned LOGFFTSIZE  = LOGFFTSIZE_DEF,
   parameter int unsigned AUDIOWIDTH  = AUDIOWIDTH_DEF,
   parameter int unsigned SATCNTWIDTH = SATCNTWIDTH_DEF
) (
   input  logic     clk,
   input  logic     rst,
   gcapply_if.slave bus
);
   localparam logic [AUDIOWIDTH-1:0] UNITY = {1'b1, {(AUDIOWIDTH-1){1'b0}}};

   logic                   bypass_d, bypass_q;
   logic                   s1_valid_q, s1_last_q, s1_byp_q;
   logic [LOGFFTSIZE-1:0]  s1_index_q;
   logic [AUDIOWIDTH-1:0]  s1_re_q, s1_im_q;
   logic                   s2_valid_q, s2_last_q;
   logic [LOGFFTSIZE-1:0]  s2_index_q;
   logic                   out_valid_q, out_last_q;
   logic [LOGFFTSIZE-1:0]  out_index_q;
   logic [SATCNTWIDTH-1:0] sat_cnt_d, sat_cnt_q, sat_frame_d, sat_frame_q, cnt_inc;
   logic [AUDIOWIDTH-1:0]  gain;
   logic signed [AUDIOWIDTH-1:0] res_re, res_im;
   logic                   sat_re, sat_im;

   // The RAM is read unconditionally; its data lines up with S1.
   assign bus.gcurve_addr = bus.in_index;

   always_comb begin
      // Any not-ready cycle forces bypass; only a ready frame start clears it.
      bypass_d = bypass_q;
      if (!bus.curve_ready)
         bypass_d = 1'b1;
      else if (bus.in_valid && bus.in_index == '0)
         bypass_d = 1'b0;
      gain = s1_byp_q ? UNITY : bus.gcurve_dout;
   end

   gcmul_sat #(.AUDIOWIDTH(AUDIOWIDTH)) u_mul_re (
      .clk_i(clk), .rst_ni(rst), .prod_en_i(s1_valid_q), .out_en_i(s2_valid_q),
      .sample_i(s1_re_q), .gain_i(gain), .result_o(res_re), .sat_o(sat_re)
   );

   gcmul_sat #(.AUDIOWIDTH(AUDIOWIDTH)) u_mul_im (
      .clk_i(clk), .rst_ni(rst), .prod_en_i(s1_valid_q), .out_en_i(s2_valid_q),
      .sample_i(s1_im_q), .gain_i(gain), .result_o(res_im), .sat_o(sat_im)
   );

   // Counter advances in step with the S3 register load so sat_frame is
   // updated on the same edge that presents out_last.
   always_comb begin
      cnt_inc = sat_cnt_q;
      if (s2_valid_q && (sat_re || sat_im) && !(&sat_cnt_q))
         cnt_inc = sat_cnt_q + 1'b1;
      sat_cnt_d   = cnt_inc;
      sat_frame_d = sat_frame_q;
      if (s2_valid_q && s2_last_q) begin
         sat_frame_d = cnt_inc;
         sat_cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bypass_q    <= 1'b1;
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_byp_q    <= 1'b1;
         s1_index_q  <= '0;
         s1_re_q     <= '0;
         s1_im_q     <= '0;
         s2_valid_q  <= 1'b0;
         s2_last_q   <= 1'b0;
         s2_index_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_index_q <= '0;
         sat_cnt_q   <= '0;
         sat_frame_q <= '0;
      end else begin
         bypass_q    <= bypass_d;
         s1_valid_q  <= bus.in_valid;
         s1_last_q   <= bus.in_last;
         s1_byp_q    <= bypass_d;
         s1_index_q  <= bus.in_index;
         s1_re_q     <= bus.in_re;
         s1_im_q     <= bus.in_im;
         s2_valid_q  <= s1_valid_q;
         s2_last_q   <= s1_valid_q & s1_last_q;
         s2_index_q  <= s1_index_q;
         out_valid_q <= s2_valid_q;
         out_last_q  <= s2_valid_q & s2_last_q;
         if (s2_valid_q) out_index_q <= s2_index_q;
         sat_cnt_q   <= sat_cnt_d;
         sat_frame_q <= sat_frame_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_index = out_index_q;
   assign bus.out_re    = res_re;
   assign bus.out_im    = res_im;
   assign bus.sat_frame = sat_frame_q;

endmodule

// File: tb/tb_gcapply.sv
// -----------------------------------------------------------------------------
// tb_gcapply
// Scoreboard bench for gcapply: the stimulus process pushes the expected bin
// for every issued input, a negedge monitor pops and compares on out_valid.
// -----------------------------------------------------------------------------
module tb_gcapply;

   typedef struct {
      int unsigned idx;
      int          re;
      int          im;
      bit          last;
      int          sat;
      int unsigned cyc;
   } exp_t;

   logic        clk;
   logic        rst;
   int unsigned cyc;
   int          n_pass;
   int          n_total;
   exp_t        q[$];
   logic [15:0] gram [0:8191];
   int          last_re, last_im;

   gcapply_if #(.LOGFFTSIZE(13), .AUDIOWIDTH(16), .SATCNTWIDTH(16)) bus ();

   gcapply #(.LOGFFTSIZE(13), .AUDIOWIDTH(16), .SATCNTWIDTH(16)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Gain-curve RAM model: synchronous read, one cycle latency.
   always @(posedge clk) bus.gcurve_dout <= gram[bus.gcurve_addr];

   task automatic check(input string name, input longint act, input longint req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         last_re = 0;
         last_im = 0;
      end else if (bus.out_valid) begin
         if (q.size() == 0) begin
            n_total++;
            $display("FAIL spurious_out_valid: got out_valid=1 index=%0d, expected no output", bus.out_index);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("out_index", bus.out_index, e.idx);
            check("out_re", $signed(bus.out_re), e.re);
            check("out_im", $signed(bus.out_im), e.im);
            check("out_last", bus.out_last, e.last);
            check("latency_cycle", cyc, e.cyc);
            if (e.last) check("sat_frame", bus.sat_frame, e.sat);
         end
         last_re = $signed(bus.out_re);
         last_im = $signed(bus.out_im);
      end else begin
         check("idle_hold_re", $signed(bus.out_re), last_re);
         check("idle_hold_im", $signed(bus.out_im), last_im);
         check("idle_out_last", bus.out_last, 0);
      end
   end

   task automatic send(input int idx, input int re, input int im, input bit last,
                       input bit rdy, input int ere, input int eim, input int esat);
      exp_t e;
      @(posedge clk);
      #1;
      bus.in_valid    = 1'b1;
      bus.in_index    = idx[12:0];
      bus.in_re       = re[15:0];
      bus.in_im       = im[15:0];
      bus.in_last     = last;
      bus.curve_ready = rdy;
      e.idx  = idx;
      e.re   = ere;
      e.im   = eim;
      e.last = last;
      e.sat  = esat;
      e.cyc  = cyc + 3;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         bus.in_valid    = 1'b0;
         bus.in_last     = 1'b0;
         bus.curve_ready = 1'b1;
      end
   endtask

   // Frame of re=1000/im=-1000; ready drops for one cycle at bin 'drop'
   // (drop<0: never); bins before the drop give 'sv', from it on unity.
   task automatic frame(input int n, input int drop, input int sv);
      for (int i = 0; i < n; i++) begin
         int v;
         v = (drop >= 0 && i >= drop) ? 1000 : sv;
         send(i, 1000, -1000, i == n - 1, i != drop, v, -v, 0);
      end
   endtask

   task automatic fill(input int g);
      for (int i = 0; i < 8192; i++) gram[i] = g[15:0];
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      last_re = 0;
      last_im = 0;
      bus.in_valid    = 1'b0;
      bus.in_index    = '0;
      bus.in_re       = '0;
      bus.in_im       = '0;
      bus.in_last     = 1'b0;
      bus.curve_ready = 1'b1;
      fill(32768);
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_out_last", bus.out_last, 0);
      check("reset_out_index", bus.out_index, 0);
      check("reset_out_re", bus.out_re, 0);
      check("reset_out_im", bus.out_im, 0);
      check("reset_sat_frame", bus.sat_frame, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      idle(2);

      // Unity curve, bins with gaps: bit-exact passthrough.
      for (int i = 0; i < 8; i++) begin
         send(i, 1000, -1000, i == 7, 1'b1, 1000, -1000, 0);
         if (i % 2 == 1) idle(1);
      end
      idle(4);

      // Half gain on bin 5: floor of -1.5 is -2, no saturation.
      gram[5] = 16'd16384;
      for (int i = 0; i < 8; i++) begin
         if (i == 5) send(5, 1000, -3, 1'b0, 1'b1, 500, -2, 0);
         else        send(i, 1000, -1000, i == 7, 1'b1, 1000, -1000, 0);
      end
      idle(4);

      // Near-2x gain on bin 7 clamps both signs; one saturated bin.
      gram[5] = 16'd32768;
      gram[7] = 16'd65535;
      for (int i = 0; i < 8; i++) begin
         if (i == 7) send(7, 30000, -32768, 1'b1, 1'b1, 32767, -32768, 1);
         else        send(i, 1000, -1000, 1'b0, 1'b1, 1000, -1000, 0);
      end
      idle(4);

      // Reset with two bins in flight; outputs clear asynchronously.
      send(0, 1000, -1000, 1'b0, 1'b1, 1000, -1000, 0);
      send(1, 1000, -1000, 1'b0, 1'b1, 1000, -1000, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      q.delete();
      #1;
      check("async_rst_out_valid", bus.out_valid, 0);
      check("async_rst_out_last", bus.out_last, 0);
      check("async_rst_out_index", bus.out_index, 0);
      check("async_rst_out_re", bus.out_re, 0);
      check("async_rst_out_im", bus.out_im, 0);
      check("async_rst_sat_frame", bus.sat_frame, 0);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      idle(6);

      fill(16384);
      // Bypass is set after reset: a stray bin before any index 0 is unity.
      send(3, 1000, -1000, 1'b0, 1'b1, 1000, -1000, 0);
      idle(2);
      frame(8, 0, 500);     // not ready at frame start: whole frame unity
      idle(2);
      frame(8, -1, 500);    // ready again: scaled
      idle(2);
      frame(120, 100, 500); // drop at bin 100: 0..99 scaled, 100.. unity
      idle(2);
      frame(8, -1, 500);    // scaled again
      idle(2);

      for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
      if (q.size() != 0) begin
         n_total++;
         $display("FAIL drain_timeout: got %0d bins outstanding, expected 0", q.size());
      end
      idle(2);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
